loop_settle_monitor: RTL and testbench

Sequential stimulus-and-observe engine for gate-level combinational-loop test structures. It drives a loop's side-input pins with a requested pattern, samples selected loop nets through synchronizers, and counts net transitions over a fixed window. It classifies the loop as settled or oscillating and reports the result with a one-cycle done pulse. It sits in the loop-checker bench and silicon harness as the reader of the nets a loop netlist produces.

---
 rtl/loop_settle_monitor_pkg.sv | 17 +
 rtl/loop_settle_monitor_if.sv | 28 ++
 rtl/loop_settle_monitor_sync2.sv | 24 ++
 rtl/loop_settle_monitor.sv | 133 +++++++++++++
 tb/tb_loop_settle_monitor.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/loop_settle_monitor_pkg.sv
// Shared types and constants for the loop settle monitor.
// Defines the FSM states, the verdict encoding and the synchronizer depth.
package loop_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    OBSERVE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam logic STABLE      = 1'b0;
  localparam logic OSCILLATING = 1'b1;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/loop_settle_monitor_if.sv
// Control/result bundle between the bench or harness sequencer and the monitor.
// The master requests measurements; the slave (the monitor) reports results.
interface loop_settle_monitor_if #(
  parameter int PIN_W   = 17,
  parameter int NET_W   = 3,
  parameter int OBS_CYC = 16
);
  localparam int CNT_W = $clog2(OBS_CYC + 1);

  logic             start;
  logic [PIN_W-1:0] pattern_in;
  logic             busy;
  logic             done;
  logic             osc;
  logic [CNT_W-1:0] toggle_cnt;
  logic [NET_W-1:0] final_net;

  modport master (
    output start, pattern_in,
    input  busy, done, osc, toggle_cnt, final_net
  );

  modport slave (
    input  start, pattern_in,
    output busy, done, osc, toggle_cnt, final_net
  );

endinterface

// File: rtl/loop_settle_monitor_sync2.sv
// Two-flop synchronizer for the asynchronous loop nets.
// Both stages clear on reset so the first compare starts from a known zero.
module sync2 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/loop_settle_monitor.sv
// Drives a loop's side pins, watches its nets for a fixed window and classifies
// the loop as settled or oscillating.
//
// state   | meaning
// IDLE    | waiting for start; pin_out keeps driving the last pattern
// APPLY   | pattern applied, synchronizers filling, reference sample loaded
// OBSERVE | OBS_CYC compare cycles, then one wrap-up cycle latching final_net
// REPORT  | done pulse; results frozen until the next start
module loop_settle_monitor
  import loop_mon_pkg::*;
#(
  parameter int PIN_W     = 17,
  parameter int NET_W     = 3,
  parameter int OBS_CYC   = 16,
  parameter int QUIET_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  loop_settle_monitor_if.slave ctl,
  output logic [PIN_W-1:0]     pin_out,
  input  logic [NET_W-1:0]     net_in
);

  localparam int CNT_W = $clog2(OBS_CYC + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] tog_cnt;
  logic             osc_q;
  logic [NET_W-1:0] final_q;
  logic [NET_W-1:0] net_sync;
  logic [NET_W-1:0] net_ref;
  logic             net_chg;

  logic             start_acc;
  logic             ld_obs;
  logic             win_dec;
  logic             ref_ld;
  logic             cmp_en;
  logic             finish;

  sync2 #(.WIDTH(NET_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (net_in),
    .q     (net_sync)
  );

  assign net_chg = |(net_sync ^ net_ref);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    ld_obs    = 1'b0;
    win_dec   = 1'b0;
    ref_ld    = 1'b0;
    cmp_en    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctl.start) begin
          start_acc = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        ref_ld = 1'b1;
        if (win_cnt == '0) begin
          ld_obs    = 1'b1;
          state_nxt = OBSERVE;
        end else begin
          win_dec = 1'b1;
        end
      end
      OBSERVE: begin
        if (win_cnt != '0) begin
          cmp_en  = 1'b1;
          win_dec = 1'b1;
        end else begin
          finish    = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // win_cnt counts down the APPLY fill and then the compare window; in OBSERVE
  // it equals the number of compares left, so the quiet tail is win_cnt <= QUIET_CYC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_out <= '0;
      win_cnt <= '0;
      tog_cnt <= '0;
      osc_q   <= STABLE;
      final_q <= '0;
      net_ref <= '0;
    end else begin
      if (start_acc) begin
        pin_out <= ctl.pattern_in;
        win_cnt <= CNT_W'(SYNC_STAGES - 1);
        tog_cnt <= '0;
        osc_q   <= STABLE;
      end else if (ld_obs) begin
        win_cnt <= CNT_W'(OBS_CYC);
      end else if (win_dec) begin
        win_cnt <= win_cnt - 1'b1;
      end

      if (ref_ld || cmp_en) net_ref <= net_sync;

      if (cmp_en && net_chg) begin
        tog_cnt <= tog_cnt + 1'b1;
        if (win_cnt <= CNT_W'(QUIET_CYC)) osc_q <= OSCILLATING;
      end

      if (finish) final_q <= net_ref;
    end
  end

  assign ctl.busy       = (state != IDLE);
  assign ctl.done       = (state == REPORT);
  assign ctl.osc        = osc_q;
  assign ctl.toggle_cnt = tog_cnt;
  assign ctl.final_net  = final_q;

endmodule

// File: tb/tb_loop_settle_monitor.sv
// Directed bench for loop_settle_monitor: table of measurement vectors driven
// through a small loop model, plus back-to-back and mid-measurement reset cases.
module tb_loop_settle_monitor;

  localparam int PIN_W     = 17;
  localparam int NET_W     = 3;
  localparam int OBS_CYC   = 16;
  localparam int QUIET_CYC = 4;

  localparam int M_HOLD   = 0;
  localparam int M_SETTLE = 1;
  localparam int M_RING   = 2;

  typedef struct {
    logic [PIN_W-1:0] pat;
    int               mode;
    logic [NET_W-1:0] init_net;
    int               chg_off;
    logic [NET_W-1:0] chg_val;
    bit               busy_pulse;
    logic             exp_osc;
    int               exp_tog;
    logic [NET_W-1:0] exp_final;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [PIN_W-1:0] pin_out;
  logic [NET_W-1:0] net_in;

  int               n_tests;
  int               n_fail;

  int               mode;
  logic [NET_W-1:0] hold_val;
  logic [PIN_W-1:0] last_pin;
  int               age;
  int               rc;

  vec_t             vecs[8];

  loop_settle_monitor_if #(.PIN_W(PIN_W), .NET_W(NET_W), .OBS_CYC(OBS_CYC)) ctl ();

  loop_settle_monitor #(
    .PIN_W     (PIN_W),
    .NET_W     (NET_W),
    .OBS_CYC   (OBS_CYC),
    .QUIET_CYC (QUIET_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctl     (ctl),
    .pin_out (pin_out),
    .net_in  (net_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Loop model: advanced once per falling edge, the only writer of net_in.
  task automatic model_step();
    if (pin_out !== last_pin) begin
      last_pin = pin_out;
      age      = 0;
    end else if (age < 1000) begin
      age++;
    end
    case (mode)
      M_HOLD:   net_in = hold_val;
      M_SETTLE: if (age == 3) net_in = hold_val;
      M_RING: begin
        if (pin_out[4]) begin
          rc++;
          if (rc == 3) begin
            net_in[0] = ~net_in[0];
            rc        = 0;
          end
        end else begin
          rc = 0;
        end
      end
      default: net_in = hold_val;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int               done_off;
    int               done_cnt;
    int               pin_bad;
    logic             busy0;
    logic             busy20;
    logic             o;
    logic [31:0]      t;
    logic [NET_W-1:0] f;
    string            nm;
    nm       = $sformatf("vec%0d", idx);
    done_off = -1;
    done_cnt = 0;
    pin_bad  = 0;
    busy0    = 1'b0;
    busy20   = 1'b1;
    o        = 1'bx;
    t        = 'x;
    f        = 'x;
    mode     = M_HOLD;
    hold_val = v.init_net;
    repeat (3) tick();
    mode = v.mode;
    if (v.mode == M_SETTLE) hold_val = v.chg_val;
    ctl.start      = 1'b1;
    ctl.pattern_in = v.pat;
    for (int off = 0; off <= 30; off++) begin
      if (v.mode == M_HOLD && off == v.chg_off) hold_val = v.chg_val;
      tick();
      if (pin_out !== v.pat) pin_bad++;
      if (off == 0)  busy0  = ctl.busy;
      if (off == 20) busy20 = ctl.busy;
      if (ctl.done === 1'b1) begin
        done_cnt++;
        if (done_off < 0) begin
          done_off = off;
          o        = ctl.osc;
          t        = 32'(ctl.toggle_cnt);
          f        = ctl.final_net;
        end
      end
      ctl.start      = v.busy_pulse && (off == 2 || off == 9 || off == 19);
      ctl.pattern_in = ctl.start ? ~v.pat : v.pat;
    end
    check({nm, " done_latency"}, 32'(done_off), 32'(OBS_CYC + 3));
    check({nm, " done_count"}, 32'(done_cnt), 32'd1);
    check({nm, " busy_at_start"}, 32'(busy0), 32'd1);
    check({nm, " busy_after_done"}, 32'(busy20), 32'd0);
    check({nm, " pin_out_stable"}, 32'(pin_bad), 32'd0);
    check({nm, " osc"}, 32'(o), 32'(v.exp_osc));
    check({nm, " toggle_cnt"}, t, 32'(v.exp_tog));
    check({nm, " final_net"}, 32'(f), 32'(v.exp_final));
    check({nm, " osc_held"}, 32'(ctl.osc), 32'(v.exp_osc));
    check({nm, " toggle_held"}, 32'(ctl.toggle_cnt), 32'(v.exp_tog));
  endtask

  initial begin
    int done_cnt;
    int busy_low;
    int first_done;
    int second_done;
    int pin_bad;

    n_tests        = 0;
    n_fail         = 0;
    mode           = M_HOLD;
    hold_val       = '0;
    last_pin       = '0;
    age            = 1000;
    rc             = 0;
    net_in         = '0;
    rst_n          = 1'b0;
    ctl.start      = 1'b0;
    ctl.pattern_in = '0;

    // pat, mode, init_net, chg_off, chg_val, busy_pulse, exp_osc, exp_tog, exp_final
    vecs[0] = '{17'h1FFFF, M_SETTLE, 3'b000, -1, 3'b110, 1'b0, 1'b0, 1, 3'b110};
    vecs[1] = '{17'h00000, M_HOLD,   3'b101, -1, 3'b101, 1'b0, 1'b0, 0, 3'b101};
    vecs[2] = '{17'h00010, M_RING,   3'b000, -1, 3'b000, 1'b0, 1'b1, 5, 3'b001};
    vecs[3] = '{17'h0AAAA, M_HOLD,   3'b010, 15, 3'b011, 1'b0, 1'b1, 1, 3'b011};
    vecs[4] = '{17'h15555, M_HOLD,   3'b011, 11, 3'b111, 1'b0, 1'b0, 1, 3'b111};
    vecs[5] = '{17'h1F00F, M_HOLD,   3'b111, 12, 3'b110, 1'b0, 1'b1, 1, 3'b110};
    vecs[6] = '{17'h00F0F, M_HOLD,   3'b110,  0, 3'b000, 1'b0, 1'b0, 1, 3'b000};
    vecs[7] = '{17'h12345, M_HOLD,   3'b011, -1, 3'b011, 1'b1, 1'b0, 0, 3'b011};

    #1;
    check("reset pin_out", 32'(pin_out), 32'd0);
    check("reset busy", 32'(ctl.busy), 32'd0);
    check("reset done", 32'(ctl.done), 32'd0);
    check("reset osc", 32'(ctl.osc), 32'd0);
    check("reset toggle_cnt", 32'(ctl.toggle_cnt), 32'd0);
    check("reset final_net", 32'(ctl.final_net), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Start held high: second measurement follows after exactly one IDLE cycle.
    mode     = M_HOLD;
    hold_val = 3'b010;
    repeat (3) tick();
    ctl.start      = 1'b1;
    ctl.pattern_in = 17'h0F0F0;
    first_done     = -1;
    second_done    = -1;
    busy_low       = 0;
    done_cnt       = 0;
    for (int off = 0; off <= 45; off++) begin
      tick();
      if (off <= 40 && ctl.busy !== 1'b1) busy_low++;
      if (ctl.done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = off;
        else if (second_done < 0) second_done = off;
      end
      if (off >= 40) ctl.start = 1'b0;
    end
    check("b2b first_done", 32'(first_done), 32'(OBS_CYC + 3));
    check("b2b second_done", 32'(second_done), 32'(2 * OBS_CYC + 8));
    check("b2b idle_cycles", 32'(busy_low), 32'd1);
    check("b2b done_count", 32'(done_cnt), 32'd2);

    // Reset asserted during OBSERVE window cycle 5.
    mode     = M_RING;
    hold_val = 3'b000;
    repeat (3) tick();
    ctl.start      = 1'b1;
    ctl.pattern_in = 17'h1F0F0;
    for (int off = 0; off <= 7; off++) begin
      tick();
      ctl.start = 1'b0;
    end
    check("rst busy_before", 32'(ctl.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst pin_out", 32'(pin_out), 32'd0);
    check("rst busy", 32'(ctl.busy), 32'd0);
    check("rst done", 32'(ctl.done), 32'd0);
    check("rst osc", 32'(ctl.osc), 32'd0);
    check("rst toggle_cnt", 32'(ctl.toggle_cnt), 32'd0);
    check("rst final_net", 32'(ctl.final_net), 32'd0);
    repeat (2) tick();
    rst_n    = 1'b1;
    done_cnt = 0;
    busy_low = 0;
    pin_bad  = 0;
    for (int off = 0; off < 30; off++) begin
      tick();
      if (ctl.done !== 1'b0) done_cnt++;
      if (ctl.busy !== 1'b0) busy_low++;
      if (pin_out !== '0) pin_bad++;
    end
    check("rst no_done", 32'(done_cnt), 32'd0);
    check("rst stays_idle", 32'(busy_low), 32'd0);
    check("rst pin_out_zero", 32'(pin_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
